// File: rtl/cpu_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_fetch_unit                                               |
// | Description : Instruction-fetch front end. Gathers BEATS narrow memory     |
// |               beats into one instruction (little-endian), hands it to      |
// |               decode over valid/ready, and flushes on branch redirect.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cpu_fetch_unit #(
  parameter int                    INSTR_WIDTH = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   busy
);

  localparam int BEATS  = INSTR_WIDTH / DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(BEATS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]             state_q,    state_d;
  logic [ADDR_WIDTH-1:0]  pc_q,       pc_d;
  logic [BEAT_W-1:0]      beat_q,     beat_d;
  logic [INSTR_WIDTH-1:0] buf_q,      buf_d;
  logic [INSTR_WIDTH-1:0] instr_q,    instr_d;
  logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
  logic                   valid_q,    valid_d;

  // Partial buffer with the current beat's data merged into its slice, so the
  // final beat can be published in the same edge it is acknowledged.
  logic [INSTR_WIDTH-1:0] w_asm;

  // A redirect suppresses the request so no beat is consumed in that cycle.
  assign mem_req     = (state_q == S_FETCH) && !redirect_valid;
  assign mem_addr    = pc_q + ADDR_WIDTH'(beat_q);
  assign busy        = (state_q == S_FETCH);
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  // Next-state logic: redirect first, then the per-state fetch/hold behaviour.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    beat_d     = beat_q;
    buf_d      = buf_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;

    w_asm = buf_q;
    w_asm[int'(beat_q) * DATA_WIDTH +: DATA_WIDTH] = mem_rdata;

    if (redirect_valid) begin
      // Flush: any partial instruction is abandoned, pending output withdrawn.
      pc_d    = redirect_pc;
      beat_d  = '0;
      valid_d = 1'b0;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack) begin
            buf_d = w_asm;
            if (beat_q == LAST_BEAT) begin
              instr_d    = w_asm;
              instr_pc_d = pc_q;
              valid_d    = 1'b1;
              pc_d       = pc_q + PC_STEP;
              beat_d     = '0;
              state_d    = S_HOLD;
            end else begin
              beat_d = beat_q + BEAT_ONE;
            end
          end
        end
        S_HOLD: begin
          if (valid_q && instr_ready) begin
            valid_d = 1'b0;
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous clear to the reset PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      beat_q     <= '0;
      buf_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      beat_q     <= beat_d;
      buf_q      <= buf_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cpu_fetch_unit                                            |
// | Description : Directed vector bench for cpu_fetch_unit, 16-bit and 32-bit  |
// |               instruction configurations sharing one byte memory.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cpu_fetch_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];

  // 16-bit configuration
  logic        req16, ack16, vld16, rdy16, rv16, busy16;
  logic [7:0]  addr16, rdata16, ipc16, rpc16;
  logic [15:0] instr16;

  // 32-bit configuration
  logic        req32, ack32, vld32, rdy32, rv32, busy32;
  logic [7:0]  addr32, rdata32, ipc32, rpc32;
  logic [31:0] instr32;

  assign rdata16 = mem[addr16];
  assign rdata32 = mem[addr32];

  cpu_fetch_unit #(
    .INSTR_WIDTH(16), .DATA_WIDTH(8), .ADDR_WIDTH(8), .RESET_PC(8'h00)
  ) u_dut16 (
    .clk(clk), .reset(reset),
    .mem_req(req16), .mem_addr(addr16), .mem_ack(ack16), .mem_rdata(rdata16),
    .instr_valid(vld16), .instr_ready(rdy16), .instr(instr16), .instr_pc(ipc16),
    .redirect_valid(rv16), .redirect_pc(rpc16), .busy(busy16)
  );

  cpu_fetch_unit #(
    .INSTR_WIDTH(32), .DATA_WIDTH(8), .ADDR_WIDTH(8), .RESET_PC(8'h00)
  ) u_dut32 (
    .clk(clk), .reset(reset),
    .mem_req(req32), .mem_addr(addr32), .mem_ack(ack32), .mem_rdata(rdata32),
    .instr_valid(vld32), .instr_ready(rdy32), .instr(instr32), .instr_pc(ipc32),
    .redirect_valid(rv32), .redirect_pc(rpc32), .busy(busy32)
  );

  typedef struct {
    logic        rdy;
    logic        ack;
    logic        rv;
    logic [7:0]  rpc;
    logic        ereq;
    logic [7:0]  eaddr;
    logic        evld;
    logic [15:0] einstr;
    logic [7:0]  eipc;
    logic        ebusy;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vt [NVEC];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rdy, input logic ack, input logic rv,
                              input logic [7:0] rpc, input logic ereq,
                              input logic [7:0] eaddr, input logic evld,
                              input logic [15:0] einstr, input logic [7:0] eipc,
                              input logic ebusy);
    vec_t v;
    v.rdy = rdy; v.ack = ack; v.rv = rv; v.rpc = rpc;
    v.ereq = ereq; v.eaddr = eaddr; v.evld = evld;
    v.einstr = einstr; v.eipc = eipc; v.ebusy = ebusy;
    return v;
  endfunction

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
    mem[8'h02] = 8'h78; mem[8'h03] = 8'h56;
    mem[8'h04] = 8'hBC; mem[8'h05] = 8'h9A;
    mem[8'h06] = 8'hEF; mem[8'h07] = 8'hCD;
    mem[8'h20] = 8'h5A; mem[8'h21] = 8'hA5;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22;
    mem[8'hFF] = 8'h99;

    //           rdy ack rv rpc    req addr   vld instr     ipc    busy
    vt[0]  = mk(0, 1, 0, 8'h00,  0, 8'h00, 0, 16'h0000, 8'h00, 0); // IDLE after reset
    vt[1]  = mk(0, 1, 0, 8'h00,  1, 8'h00, 0, 16'h0000, 8'h00, 1);
    vt[2]  = mk(0, 1, 0, 8'h00,  1, 8'h01, 0, 16'h0000, 8'h00, 1);
    vt[3]  = mk(0, 1, 0, 8'h00,  0, 8'h02, 1, 16'h1234, 8'h00, 0); // first instr
    vt[4]  = mk(0, 1, 0, 8'h00,  0, 8'h02, 1, 16'h1234, 8'h00, 0); // held
    vt[5]  = mk(1, 1, 0, 8'h00,  0, 8'h02, 1, 16'h1234, 8'h00, 0); // accepted
    vt[6]  = mk(1, 1, 0, 8'h00,  1, 8'h02, 0, 16'h1234, 8'h00, 1); // instr kept
    vt[7]  = mk(1, 1, 0, 8'h00,  1, 8'h03, 0, 16'h1234, 8'h00, 1);
    vt[8]  = mk(1, 1, 0, 8'h00,  0, 8'h04, 1, 16'h5678, 8'h02, 0);
    vt[9]  = mk(1, 1, 0, 8'h00,  1, 8'h04, 0, 16'h5678, 8'h02, 1);
    vt[10] = mk(1, 1, 0, 8'h00,  1, 8'h05, 0, 16'h5678, 8'h02, 1);
    vt[11] = mk(1, 1, 0, 8'h00,  0, 8'h06, 1, 16'h9ABC, 8'h04, 0);
    vt[12] = mk(0, 1, 0, 8'h00,  1, 8'h06, 0, 16'h9ABC, 8'h04, 1);
    vt[13] = mk(0, 0, 0, 8'h00,  1, 8'h07, 0, 16'h9ABC, 8'h04, 1); // stall x4
    vt[14] = mk(0, 0, 0, 8'h00,  1, 8'h07, 0, 16'h9ABC, 8'h04, 1);
    vt[15] = mk(0, 0, 0, 8'h00,  1, 8'h07, 0, 16'h9ABC, 8'h04, 1);
    vt[16] = mk(0, 0, 0, 8'h00,  1, 8'h07, 0, 16'h9ABC, 8'h04, 1);
    vt[17] = mk(0, 1, 0, 8'h00,  1, 8'h07, 0, 16'h9ABC, 8'h04, 1);
    vt[18] = mk(1, 1, 0, 8'h00,  0, 8'h08, 1, 16'hCDEF, 8'h06, 0);
    vt[19] = mk(1, 1, 0, 8'h00,  1, 8'h08, 0, 16'hCDEF, 8'h06, 1);
    vt[20] = mk(1, 1, 1, 8'h40,  0, 8'h09, 0, 16'hCDEF, 8'h06, 1); // redirect in beat 1
    vt[21] = mk(1, 1, 0, 8'h00,  1, 8'h40, 0, 16'hCDEF, 8'h06, 1);
    vt[22] = mk(1, 1, 0, 8'h00,  1, 8'h41, 0, 16'hCDEF, 8'h06, 1);
    vt[23] = mk(0, 1, 0, 8'h00,  0, 8'h42, 1, 16'h2211, 8'h40, 0);
    vt[24] = mk(1, 1, 1, 8'hFF,  0, 8'h42, 1, 16'h2211, 8'h40, 0); // redirect + handshake
    vt[25] = mk(1, 1, 0, 8'h00,  1, 8'hFF, 0, 16'h2211, 8'h40, 1);
    vt[26] = mk(1, 1, 0, 8'h00,  1, 8'h00, 0, 16'h2211, 8'h40, 1); // address wrap
    vt[27] = mk(0, 1, 0, 8'h00,  0, 8'h01, 1, 16'h3499, 8'hFF, 0); // pc wrapped to 1
    vt[28] = mk(0, 1, 1, 8'h10,  0, 8'h01, 1, 16'h3499, 8'hFF, 0); // back-to-back
    vt[29] = mk(0, 1, 1, 8'h20,  0, 8'h10, 0, 16'h3499, 8'hFF, 1); //   redirects
    vt[30] = mk(0, 1, 0, 8'h00,  1, 8'h20, 0, 16'h3499, 8'hFF, 1);
    vt[31] = mk(0, 1, 0, 8'h00,  1, 8'h21, 0, 16'h3499, 8'hFF, 1);
    vt[32] = mk(0, 1, 0, 8'h00,  0, 8'h22, 1, 16'hA55A, 8'h20, 0);

    reset = 1'b0;
    rdy16 = 1'b0; ack16 = 1'b0; rv16 = 1'b0; rpc16 = 8'h00;
    rdy32 = 1'b0; ack32 = 1'b0; rv32 = 1'b0; rpc32 = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Table-driven run on the 16-bit unit: one row per clock cycle.
    for (int i = 0; i < NVEC; i++) begin
      rdy16 = vt[i].rdy; ack16 = vt[i].ack; rv16 = vt[i].rv; rpc16 = vt[i].rpc;
      #1;
      chk($sformatf("v%0d.req",   i), 32'(req16),   32'(vt[i].ereq));
      chk($sformatf("v%0d.addr",  i), 32'(addr16),  32'(vt[i].eaddr));
      chk($sformatf("v%0d.valid", i), 32'(vld16),   32'(vt[i].evld));
      chk($sformatf("v%0d.instr", i), 32'(instr16), 32'(vt[i].einstr));
      chk($sformatf("v%0d.pc",    i), 32'(ipc16),   32'(vt[i].eipc));
      chk($sformatf("v%0d.busy",  i), 32'(busy16),  32'(vt[i].ebusy));
      @(negedge clk);
    end
    rv16 = 1'b0;

    // Asynchronous reset while holding an instruction.
    #2 reset = 1'b0;
    #1;
    chk("rst_hold.valid", 32'(vld16),   32'h0);
    chk("rst_hold.req",   32'(req16),   32'h0);
    chk("rst_hold.busy",  32'(busy16),  32'h0);
    chk("rst_hold.addr",  32'(addr16),  32'h00);
    chk("rst_hold.instr", 32'(instr16), 32'h0000);
    chk("rst_hold.pc",    32'(ipc16),   32'h00);

    @(negedge clk);
    rdy16 = 1'b0; ack16 = 1'b1;
    reset = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1; edges++;
    end while (!vld16 && edges < 10);
    chk("restart.latency", 32'(edges),   32'd3);
    chk("restart.instr",   32'(instr16), 32'h1234);
    chk("restart.pc",      32'(ipc16),   32'h00);

    // 32-bit configuration: four beats per instruction.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rdy32 = 1'b0; ack32 = 1'b1;
    #1;
    chk("w32.idle.req",  32'(req32),  32'h0);
    chk("w32.idle.addr", 32'(addr32), 32'h00);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      chk($sformatf("w32.b%0d.req",  b), 32'(req32),  32'h1);
      chk($sformatf("w32.b%0d.addr", b), 32'(addr32), 32'(b));
      chk($sformatf("w32.b%0d.vld",  b), 32'(vld32),  32'h0);
    end
    @(posedge clk); #1;
    chk("w32.i0.valid", 32'(vld32),   32'h1);
    chk("w32.i0.instr", instr32,      32'h5678_1234);
    chk("w32.i0.pc",    32'(ipc32),   32'h00);
    rdy32 = 1'b1;
    @(posedge clk); #1;
    chk("w32.accept.valid", 32'(vld32),  32'h0);
    chk("w32.next.addr",    32'(addr32), 32'h04);
    edges = 0;
    do begin
      @(posedge clk); #1; edges++;
    end while (!vld32 && edges < 20);
    chk("w32.i1.latency", 32'(edges), 32'd4);
    chk("w32.i1.instr",   instr32,    32'hCDEF_9ABC);
    chk("w32.i1.pc",      32'(ipc32), 32'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the lab CPU.
- Assembles one INSTR_WIDTH-bit instruction from INSTR_WIDTH/DATA_WIDTH consecutive DATA_WIDTH-bit memory beats over a req/ack memory handshake.
- Presents each assembled instruction, with its PC, to decode over a valid/ready handshake.
- Supports a branch/jump redirect that flushes in-flight fetch state.
- Sits between instruction memory and the cpu decode stage, replacing the single-cycle fixed-width fetch.

Parameters:
- INSTR_WIDTH, 16: instruction width in bits. Must be an integer multiple of DATA_WIDTH.
- DATA_WIDTH, 8: memory data-bus width in bits.
- ADDR_WIDTH, 8: memory address / PC width, byte-granular per DATA_WIDTH word.
- RESET_PC, 0: PC loaded on reset.
- Derived: BEATS = INSTR_WIDTH/DATA_WIDTH (default 2); BEAT_W = max(1, clog2(BEATS)).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted when 0.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_WIDTH  read address: pc + beat, mod 2^ADDR_WIDTH.
- mem_ack  input  1  memory accepted request; mem_rdata valid this cycle.
- mem_rdata  input  DATA_WIDTH  read data.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts instruction.
- instr  output  INSTR_WIDTH  assembled instruction.
- instr_pc  output  ADDR_WIDTH  address of beat 0 of instr.
- redirect_valid  input  1  load new PC, flush.
- redirect_pc  input  ADDR_WIDTH  redirect target.
- busy  output  1  high while in FETCH.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE, pc=RESET_PC, beat=0, assembly buffer=0.
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=RESET_PC, busy=0.
- Reset is honoured mid-fetch and mid-hold. A partial instruction is discarded; there is no output glitch beyond the async clear.
- States: IDLE, FETCH, HOLD.
  - mem_req = (state==FETCH) && !redirect_valid.
  - busy = (state==FETCH).
- IDLE:
  - Entered only from reset.
  - Next edge -> FETCH, unless redirect_valid, in which case pc=redirect_pc first, then FETCH.
- FETCH:
  - mem_addr = pc + beat (wraps mod 2^ADDR_WIDTH). Held stable while mem_req=1 && mem_ack=0; memory may stall indefinitely.
  - On mem_req && mem_ack: mem_rdata is stored in slice [beat*DATA_WIDTH +: DATA_WIDTH] (little-endian; beat 0 = LSBs), and beat increments.
  - On ack of beat BEATS-1, at the same edge:
    - instr <= assembled value, including the current beat's data;
    - instr_pc <= pc; instr_valid <= 1;
    - pc <= pc + BEATS (wraps); beat <= 0;
    - state -> HOLD.
- HOLD:
  - mem_req=0. instr/instr_pc stay stable while instr_valid && !instr_ready.
  - On instr_valid && instr_ready: instr_valid <= 0 and state -> FETCH at that edge.
- Latency and throughput with mem_ack tied high:
  - first instr_valid rises 1 (IDLE) + BEATS edges after reset release;
  - throughput is one instruction per BEATS+1 cycles with instr_ready tied high.
- redirect_valid has highest priority in every state:
  - at the edge: pc <= redirect_pc, beat <= 0, instr_valid <= 0, state -> FETCH;
  - mem_req is forced 0 in the redirect cycle, so no beat is consumed and any mem_ack that cycle is ignored;
  - redirect in the same cycle as an instr handshake: the handshake completes for the consumer, and the fetch unit still flushes;
  - consecutive redirects: the last one wins.
- instr holds its last value after instr_valid drops; it is not cleared.

Test Plan:
- Reset then release, mem_ack=1, memory[0]=0x34, memory[1]=0x12, instr_ready=0 -> mem_addr 0 then 1; instr=0x1234, instr_pc=0x00, instr_valid=1 three edges after release; held until ready.
- instr_ready=1, ack always high, memory[2..5]=0x78,0x56,0xBC,0x9A -> instr 0x5678 @pc 2, then 0x9ABC @pc 4; instr_valid pulses one cycle each, every 3 cycles.
- mem_ack held low 4 cycles on beat 1 -> mem_req stays 1, mem_addr stays pc+1, no instr_valid until ack; assembled value correct.
- Redirect to 0x40 during beat 1 of a fetch -> partial discarded, mem_req=0 that cycle; next mem_addr=0x40; instr_pc=0x40.
- pc=0xFF with ADDR_WIDTH=8 -> beat addresses 0xFF then 0x00; next pc=0x01.
- Reset asserted while instr_valid=1 in HOLD -> instr_valid, mem_req, busy drop immediately; restart from RESET_PC.
- Re-run with INSTR_WIDTH=32, DATA_WIDTH=8 -> four beats, little-endian assembly, pc += 4.
